ram_readback_module: RTL and testbench

- Downstream stage of the ROM-to-RAM copy controller.
- After a copy completes, it sweeps the RAM from address 0 to DEPTH-1 through its synchronous read port.
- Each word is presented on a valid/ready output stream, and an optional running checksum is kept.
- It uses the same start_sig/done_sig handshake as the copy controller, so a top-level sequencer can chain the two blocks.

---
 rtl/ram_readback_module_if.sv | 12 +
 rtl/ram_readback_module.sv | 138 +++++++++++++
 tb/tb_ram_readback_module.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_readback_module_if.sv
// Valid/ready word stream leaving ram_readback_module.
// The master drives data/valid and the consumer drives ready.
interface ram_readback_module_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ram_readback_module.sv
// Sweeps a synchronous-read RAM from address 0 to DEPTH-1 after a copy and streams each word out.
// Define READBACK_SUM_EN to build the running checksum of accepted words; otherwise sum is tied to 0.
module ram_readback_module #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_sig,
  output logic                       done_sig,
  output logic [ADDR_W-1:0]          ram_addr,
  input  logic [DATA_W-1:0]          ram_data,
  ram_readback_module_if.master      o_stream,
  output logic [DATA_W+ADDR_W-1:0]   sum,
  output logic                       busy
);

  localparam int SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAP,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic              r_valid;
  logic              w_valid_next;
  logic              r_done;
  logic              w_done_next;
  logic              w_start;
  logic              w_accept;

  // A dropped start in SEND wins over a handshake, so acceptance requires start still high.
  assign w_start  = (r_state == S_IDLE) && start_sig;
  assign w_accept = (r_state == S_SEND) && start_sig && r_valid && o_stream.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_done_next  = 1'b0;

    if ((r_state inside {S_ADDR, S_CAP, S_SEND}) && !start_sig) begin
      w_state_next = S_IDLE;
      w_valid_next = 1'b0;
      w_addr_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_addr_next  = '0;
            w_state_next = S_ADDR;
          end
        end
        S_ADDR: begin
          w_state_next = S_CAP;
        end
        S_CAP: begin
          w_data_next  = ram_data;
          w_valid_next = 1'b1;
          w_state_next = S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            w_valid_next = 1'b0;
            if (r_addr == LAST_ADDR) begin
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_addr_next  = r_addr + 1'b1;
              w_state_next = S_ADDR;
            end
          end
        end
        S_DONE: begin
          if (!start_sig) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

`ifdef READBACK_SUM_EN
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + SUM_W'(r_data);
    end
  end

  assign sum = r_sum;
`else
  assign sum = '0;
`endif

  assign done_sig           = r_done;
  assign ram_addr           = r_addr;
  assign o_stream.out_data  = r_data;
  assign o_stream.out_valid = r_valid;
  assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_readback_module.sv
// Directed and randomized bench for ram_readback_module with a behavioural RAM and word/sum/timing model.
// Expected words come from the RAM contents in order; expected done time is 3*DEPTH+1 cycles plus stall cycles.
module tb_ram_readback_module;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int SUM_W     = DATA_W + ADDR_W;
  localparam int BUDGET    = 400;
  localparam int BASE_DONE = 3 * DEPTH + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_sig;
  logic              done_sig;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] mem [DEPTH];

  int checks    = 0;
  int failures  = 0;
  int doneCycle = 0;
  int accepted  = 0;
  int stalls    = 0;
  int modelSum  = 0;

  ram_readback_module_if #(.DATA_W(DATA_W)) streamIf ();

  ram_readback_module #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_sig(start_sig),
    .done_sig (done_sig),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .o_stream (streamIf),
    .sum      (sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one clock after the address is sampled.
  always @(posedge clk) ram_data <= mem[ram_addr];

  function automatic int expSum(input int total);
`ifdef READBACK_SUM_EN
    return total % (1 << SUM_W);
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_done"}, done_sig, 0);
    checkOutput({tag, "_addr"}, ram_addr, 0);
    checkOutput({tag, "_data"}, streamIf.out_data, 0);
    checkOutput({tag, "_valid"}, streamIf.out_valid, 0);
    checkOutput({tag, "_sum"}, sum, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // readyMode 0: always ready, 1: stall stallLen cycles on stallWord, 2: random ready.
  // abortWord/resetWord (-1 to disable) end the sweep by dropping start or asserting reset.
  task automatic applyStimulus(input int readyMode, input int stallWord, input int stallLen,
                               input int abortWord, input int resetWord);
    int  cycle;
    int  stallCnt;
    bit  stop;
    bit  ready;
    cycle     = 0;
    stallCnt  = 0;
    stop      = 1'b0;
    doneCycle = -1;
    accepted  = 0;
    stalls    = 0;
    modelSum  = 0;
    start_sig = 1'b1;
    streamIf.out_ready = 1'b1;
    while (!stop && cycle < BUDGET) begin
      tick();
      cycle++;
      if (done_sig) begin
        doneCycle = cycle;
        stop = 1'b1;
      end else begin
        checkOutput("busy_sweep", busy, 1);
        if (streamIf.out_valid) begin
          if (accepted >= DEPTH) begin
            checkOutput("extra_word", streamIf.out_valid, 0);
            stop = 1'b1;
          end else begin
            checkOutput("out_data", streamIf.out_data, mem[accepted]);
            checkOutput("ram_addr", ram_addr, accepted);
            if (accepted == abortWord) begin
              start_sig = 1'b0;
              streamIf.out_ready = 1'b0;
              stop = 1'b1;
            end else if (accepted == resetWord) begin
              rst_n = 1'b0;
              start_sig = 1'b0;
              stop = 1'b1;
            end else begin
              if (readyMode == 1)      ready = !(accepted == stallWord && stallCnt < stallLen);
              else if (readyMode == 2) ready = ($urandom_range(0, 3) != 0);
              else                     ready = 1'b1;
              streamIf.out_ready = ready;
              if (ready) begin
                modelSum += int'(mem[accepted]);
                accepted++;
              end else begin
                stalls++;
                stallCnt++;
              end
            end
          end
        end else if (readyMode == 2) begin
          streamIf.out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    checkOutput("sweep_finished", stop, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_sig = 1'b0;
    streamIf.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
    tick();
    tick();
    checkIdleZero("reset");
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", busy, 0);

    // Full sweep with ready tied high, then start held 10 cycles past done.
    applyStimulus(0, -1, 0, -1, -1);
    checkOutput("s1_done_cycle", doneCycle, BASE_DONE);
    checkOutput("s1_words", accepted, DEPTH);
    checkOutput("s1_sum", sum, expSum(modelSum));
    checkOutput("s1_busy_in_done", busy, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_done", done_sig, 0);
      checkOutput("hold_valid", streamIf.out_valid, 0);
      checkOutput("hold_busy", busy, 1);
      checkOutput("hold_sum", sum, expSum(modelSum));
    end
    start_sig = 1'b0;
    tick();
    checkOutput("s1_busy_idle", busy, 0);
    checkOutput("s1_sum_after", sum, expSum(modelSum));

    // Back-pressure on word 3 for five cycles.
    applyStimulus(1, 3, 5, -1, -1);
    checkOutput("s2_stalls_seen", stalls, 5);
    checkOutput("s2_done_cycle", doneCycle, BASE_DONE + stalls);
    checkOutput("s2_words", accepted, DEPTH);
    checkOutput("s2_sum", sum, expSum(modelSum));
    start_sig = 1'b0;
    tick();
    checkOutput("s2_busy_idle", busy, 0);

    // Abort while word index 5 waits in SEND.
    applyStimulus(0, -1, 0, 5, -1);
    tick();
    checkOutput("abort_valid", streamIf.out_valid, 0);
    checkOutput("abort_addr", ram_addr, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done_sig, 0);
    checkOutput("abort_sum", sum, expSum(modelSum));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_done", done_sig, 0);
      checkOutput("abort_sum_hold", sum, expSum(modelSum));
    end

    // Mid-sweep reset at word index 8.
    applyStimulus(0, -1, 0, -1, 8);
    tick();
    checkIdleZero("midreset");
    rst_n = 1'b1;
    tick();

    // Random RAM contents with random back-pressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    applyStimulus(2, -1, 0, -1, -1);
    checkOutput("rand_done_cycle", doneCycle, BASE_DONE + stalls);
    checkOutput("rand_words", accepted, DEPTH);
    checkOutput("rand_sum", sum, expSum(modelSum));
    start_sig = 1'b0;
    tick();
    checkOutput("rand_busy_idle", busy, 0);

    // All-ones RAM exercises the widest checksum.
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    applyStimulus(0, -1, 0, -1, -1);
    checkOutput("ff_done_cycle", doneCycle, BASE_DONE);
    checkOutput("ff_words", accepted, DEPTH);
    checkOutput("ff_sum", sum, expSum(modelSum));
    start_sig = 1'b0;
    tick();
    checkOutput("ff_busy_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
